// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces NUM_BTN raw push-button keys.
// Each channel passes through a polarity stage, a two-flop synchroniser and a
// stability counter; a changed level is accepted only after it has been seen
// for DEBOUNCE_CYCLES consecutive cycles. Outputs are a held level (buttons)
// and a registered single-cycle press pulse (pressed).
// Optional feature macro: BTN_COND_RELEASE_EN adds a registered release pulse
// output (released) on each accepted 1->0 transition.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] key_in,
  output logic [NUM_BTN-1:0] buttons,
  output logic [NUM_BTN-1:0] pressed
`ifdef BTN_COND_RELEASE_EN
  ,
  output logic [NUM_BTN-1:0] released
`endif
);

  // Per-channel debounce FSM encoding.
  localparam logic ST_IDLE  = 1'b0;  // sync2 agrees with buttons, cnt held at 0
  localparam logic ST_COUNT = 1'b1;  // sync2 disagrees, cnt measuring stability

  // Last count value of a mismatch run; reaching it with the mismatch still
  // present accepts the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] state;
  logic [NUM_BTN-1:0] accept;
  logic [CNT_W-1:0]   cnt [NUM_BTN];

  // Normalise key polarity so everything downstream is active-high.
  assign raw = (ACTIVE_LOW != 0) ? ~key_in : key_in;

  // Two-stage synchroniser; reset to the released (0) level so a key held
  // through reset is treated as a fresh mismatch.
  // NOTE: sequential state uses non-blocking (<=) assignments so every flop
  // samples the pre-edge value of its source, giving a true two-stage chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Acceptance strobe: the final mismatch cycle of a long-enough run.
  // NOTE: every combinational output is given a default before the loop so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      accept[i] = (state[i] == ST_COUNT) && (sync2[i] != buttons[i]) &&
                  (cnt[i] == CNT_LAST);
    end
  end

  // Per-channel debounce FSM: count consecutive mismatch cycles, load the
  // stable level on acceptance, abandon the run on any return to agreement.
  // NOTE: the counter array is small and is reset along with the FSM, so a
  // reset mid-count cannot leave a partial run that would shorten the next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= '0;
      buttons <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (sync2[i] != buttons[i]) begin
              // First mismatch cycle is counted here (cnt 0 -> 1).
              state[i] <= ST_COUNT;
              cnt[i]   <= CNT_W'(1);
            end else begin
              cnt[i] <= '0;
            end
          end
          default: begin
            if (sync2[i] == buttons[i]) begin
              state[i] <= ST_IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]   <= ST_IDLE;
              cnt[i]     <= '0;
              buttons[i] <= sync2[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  // Edge pulses, registered alongside the buttons load so each pulse lines
  // up with the first cycle of the new level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed <= '0;
    end else begin
      pressed <= accept & sync2;
    end
  end

`ifdef BTN_COND_RELEASE_EN
  // Release pulse on each accepted 1->0 transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      released <= '0;
    end else begin
      released <= accept & ~sync2;
    end
  end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed self-checking bench for button_conditioner
// with DEBOUNCE_CYCLES=8 and ACTIVE_LOW=1. Inputs change 1 ns after a rising
// edge and outputs are sampled 1 ns after each rising edge, so a clean key
// change shows up on buttons/pressed on the 10th rising edge after the drive.
// When BTN_COND_RELEASE_EN is defined the released output is also checked.
module tb_button_conditioner;

  localparam int NB  = 4;
  localparam int DEB = 8;

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] key_in;
  logic [NB-1:0] buttons;
  logic [NB-1:0] pressed;
`ifdef BTN_COND_RELEASE_EN
  logic [NB-1:0] released;
`endif

  int n_checks;
  int n_pass;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key_in  (key_in),
    .buttons (buttons),
    .pressed (pressed)
`ifdef BTN_COND_RELEASE_EN
    ,
    .released(released)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report it when the observed value differs.
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n edges during which the level must hold at exp_b with no pulses.
  task automatic quiet(input string tag, input int n, input logic [NB-1:0] exp_b);
    for (int k = 0; k < n; k++) begin
      step();
      check({tag, "_buttons"}, 32'(buttons), 32'(exp_b));
      check({tag, "_pressed"}, 32'(pressed), 32'h0);
`ifdef BTN_COND_RELEASE_EN
      check({tag, "_released"}, 32'(released), 32'h0);
`endif
    end
  endtask

  // One edge at which specific level and pulse values are required.
  task automatic edge_chk(input string tag, input logic [NB-1:0] exp_b,
                          input logic [NB-1:0] exp_p, input logic [NB-1:0] exp_r);
    step();
    check({tag, "_buttons"}, 32'(buttons), 32'(exp_b));
    check({tag, "_pressed"}, 32'(pressed), 32'(exp_p));
`ifdef BTN_COND_RELEASE_EN
    check({tag, "_released"}, 32'(released), 32'(exp_r));
`else
    if (exp_r !== exp_r) $display("unreachable");
`endif
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    key_in   = 4'b0000;

    // Reset held with all keys pressed: outputs stay 0 throughout.
    #1;
    quiet("rst_hold", 20, 4'b0000);
    reset_n = 1'b1;
    quiet("rst_lat", 9, 4'b0000);
    edge_chk("rst_press", 4'b1111, 4'b1111, 4'b0000);
    quiet("rst_after", 2, 4'b1111);
    key_in = 4'b1111;
    quiet("rst_rel_lat", 9, 4'b1111);
    edge_chk("rst_release", 4'b0000, 4'b0000, 4'b1111);
    quiet("rst_idle", 3, 4'b0000);

    // Clean press and release on channel 0.
    key_in = 4'b1110;
    quiet("clean_lat", 9, 4'b0000);
    edge_chk("clean_press", 4'b0001, 4'b0001, 4'b0000);
    quiet("clean_held", 3, 4'b0001);
    key_in = 4'b1111;
    quiet("clean_rel_lat", 9, 4'b0001);
    edge_chk("clean_release", 4'b0000, 4'b0000, 4'b0001);
    quiet("clean_idle", 2, 4'b0000);

    // Bounce on channel 1: 3-cycle segments never reach acceptance.
    for (int seg = 0; seg < 10; seg++) begin
      key_in = (seg % 2 == 0) ? 4'b1101 : 4'b1111;
      quiet("bounce", 3, 4'b0000);
    end
    key_in = 4'b1101;
    quiet("bounce_lat", 9, 4'b0000);
    edge_chk("bounce_press", 4'b0010, 4'b0010, 4'b0000);
    quiet("bounce_held", 2, 4'b0010);
    key_in = 4'b1111;
    quiet("bounce_rel_lat", 9, 4'b0010);
    edge_chk("bounce_release", 4'b0000, 4'b0000, 4'b0010);
    quiet("bounce_idle", 2, 4'b0000);

    // Channel 2 glitch of 7 cycles: rejected.
    key_in = 4'b1011;
    quiet("glitch7_low", 7, 4'b0000);
    key_in = 4'b1111;
    quiet("glitch7_after", 12, 4'b0000);

    // Channel 2 glitch of 8 cycles: accepted, then released 8 cycles later.
    key_in = 4'b1011;
    quiet("glitch8_low", 8, 4'b0000);
    key_in = 4'b1111;
    quiet("glitch8_tail", 1, 4'b0000);
    edge_chk("glitch8_press", 4'b0100, 4'b0100, 4'b0000);
    quiet("glitch8_held", 7, 4'b0100);
    edge_chk("glitch8_release", 4'b0000, 4'b0000, 4'b0100);
    quiet("glitch8_idle", 2, 4'b0000);

    // All four channels pressed on the same edge.
    key_in = 4'b0000;
    quiet("simul_lat", 9, 4'b0000);
    edge_chk("simul_press", 4'b1111, 4'b1111, 4'b0000);
    quiet("simul_held", 2, 4'b1111);
    key_in = 4'b1111;
    quiet("simul_rel_lat", 9, 4'b1111);
    edge_chk("simul_release", 4'b0000, 4'b0000, 4'b1111);
    quiet("simul_idle", 2, 4'b0000);

    // Reset asserted mid-count on channel 3 with the key kept held.
    key_in = 4'b0111;
    quiet("midrst_pre", 5, 4'b0000);
    reset_n = 1'b0;
    quiet("midrst_hold", 2, 4'b0000);
    reset_n = 1'b1;
    quiet("midrst_lat", 9, 4'b0000);
    edge_chk("midrst_press", 4'b1000, 4'b1000, 4'b0000);
    quiet("midrst_held", 2, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
